// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with BYPASS, IDCODE and one external watch chain.
// Everything runs on TCK; TDO/TDOEn launch on the falling edge.
module jtag_tap_ctrl #(
    parameter int unsigned          IRWIDTH    = 4,
    parameter logic [31:0]          IDCODE     = 32'h1000_0001,
    parameter logic [IRWIDTH-1:0]   WATCHINSTR = 'h2
) (
    input  logic       TCK,
    input  logic       nTRST,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic       TDOEn,
    output logic       ChainScanIn,
    input  logic       ChainScanOut,
    output logic       CaptureDR,
    output logic       ShiftDR,
    output logic       UpdateDR,
    output logic [3:0] TapState
);

    localparam logic [3:0] TLR      = 4'hF;
    localparam logic [3:0] RTI      = 4'hC;
    localparam logic [3:0] SEL_DR   = 4'h7;
    localparam logic [3:0] CAP_DR   = 4'h6;
    localparam logic [3:0] SH_DR    = 4'h2;
    localparam logic [3:0] EX1_DR   = 4'h1;
    localparam logic [3:0] PAUSE_DR = 4'h3;
    localparam logic [3:0] EX2_DR   = 4'h0;
    localparam logic [3:0] UPD_DR   = 4'h5;
    localparam logic [3:0] SEL_IR   = 4'h4;
    localparam logic [3:0] CAP_IR   = 4'hE;
    localparam logic [3:0] SH_IR    = 4'hA;
    localparam logic [3:0] EX1_IR   = 4'h9;
    localparam logic [3:0] PAUSE_IR = 4'hB;
    localparam logic [3:0] EX2_IR   = 4'h8;
    localparam logic [3:0] UPD_IR   = 4'hD;

    localparam logic [IRWIDTH-1:0] OP_IDCODE = IRWIDTH'(1);

    logic [3:0]         state;
    logic [3:0]         next_state;
    logic [IRWIDTH-1:0] ir;
    logic [IRWIDTH-1:0] ir_sr;
    logic               bypass_reg;
    logic [31:0]        idcode_sr;
    logic               op_bypass;
    logic               sel_idcode;
    logic               sel_watch;
    logic               dr_serial;

    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = TMS ? TLR      : RTI;
            RTI:      next_state = TMS ? SEL_DR   : RTI;
            SEL_DR:   next_state = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = TMS ? EX1_DR   : SH_DR;
            SH_DR:    next_state = TMS ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = TMS ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = TMS ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = TMS ? SEL_DR   : RTI;
            SEL_IR:   next_state = TMS ? TLR      : CAP_IR;
            CAP_IR:   next_state = TMS ? EX1_IR   : SH_IR;
            SH_IR:    next_state = TMS ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = TMS ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = TMS ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = TMS ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    // IR is forced to IDCODE on any edge that lands in TLR, so it already
    // holds IDCODE for the whole time the TAP sits in TLR.
    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            ir    <= OP_IDCODE;
            ir_sr <= '0;
        end else begin
            if (state == CAP_IR) begin
                ir_sr <= OP_IDCODE;
            end else if (state == SH_IR) begin
                ir_sr <= {TDI, ir_sr[IRWIDTH-1:1]};
            end
            if (next_state == TLR) begin
                ir <= OP_IDCODE;
            end else if (state == UPD_IR) begin
                ir <= ir_sr;
            end
        end
    end

    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            bypass_reg <= 1'b0;
            idcode_sr  <= IDCODE;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
            idcode_sr  <= IDCODE;
        end else if (state == SH_DR) begin
            bypass_reg <= TDI;
            idcode_sr  <= {TDI, idcode_sr[31:1]};
        end
    end

    // All-ones wins over everything; unknown opcodes fall back to BYPASS.
    always_comb begin
        op_bypass  = (ir == '1);
        sel_idcode = !op_bypass && (ir == OP_IDCODE);
        sel_watch  = !op_bypass && !sel_idcode && (ir == WATCHINSTR);
        if (sel_idcode) begin
            dr_serial = idcode_sr[0];
        end else if (sel_watch) begin
            dr_serial = ChainScanOut;
        end else begin
            dr_serial = bypass_reg;
        end
    end

    always_ff @(negedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            TDO   <= 1'b0;
            TDOEn <= 1'b0;
        end else begin
            TDOEn <= (state == SH_DR) || (state == SH_IR);
            if (state == SH_IR) begin
                TDO <= ir_sr[0];
            end else if (state == SH_DR) begin
                TDO <= dr_serial;
            end
        end
    end

    assign ChainScanIn = TDI;
    assign CaptureDR   = (state == CAP_DR) && sel_watch;
    assign ShiftDR     = (state == SH_DR)  && sel_watch;
    assign UpdateDR    = (state == UPD_DR) && sel_watch;
    assign TapState    = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: FSM walk, IR/DR scans, watch strobes, resets.
module tb_jtag_tap_ctrl;

    logic       TCK = 1'b0;
    logic       nTRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO;
    logic       TDOEn;
    logic       ChainScanIn;
    logic       ChainScanOut = 1'b0;
    logic       CaptureDR;
    logic       ShiftDR;
    logic       UpdateDR;
    logic [3:0] TapState;

    int   compared = 0;
    int   mismatched = 0;
    logic last_tdo;
    logic last_tdoen;

    jtag_tap_ctrl dut (
        .TCK          (TCK),
        .nTRST        (nTRST),
        .TMS          (TMS),
        .TDI          (TDI),
        .TDO          (TDO),
        .TDOEn        (TDOEn),
        .ChainScanIn  (ChainScanIn),
        .ChainScanOut (ChainScanOut),
        .CaptureDR    (CaptureDR),
        .ShiftDR      (ShiftDR),
        .UpdateDR     (UpdateDR),
        .TapState     (TapState)
    );

    always #10 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TCK cycle: sample TDO/TDOEn just after the falling edge (they reflect
    // the state held before this cycle's rising edge), then drive and clock.
    task automatic clk(input logic tms, input logic tdi);
        @(negedge TCK);
        #1;
        last_tdo   = TDO;
        last_tdoen = TDOEn;
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic go_tlr();
        repeat (5) clk(1'b1, 1'b0);
    endtask

    // From TLR or RTI: select DR, shift 32 bits out, finish in RTI.
    task automatic read_dr32(output logic [31:0] v);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            clk(i == 31, 1'b0);
            v[i] = last_tdo;
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    // From RTI: scan val into IR (LSB first), return the captured bits, finish in RTI.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clk(i == 3, val[i]);
            cap[i] = last_tdo;
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic walk(input logic [7:0] path, input int len, input logic [3:0] code);
        go_tlr();
        for (int j = 0; j < len; j++) clk(path[j], 1'b0);
        check("walk_reach", 32'(TapState), 32'(code));
        go_tlr();
        check("walk_to_tlr", 32'(TapState), 32'hF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [3:0]  cap;
        logic [4:0]  g;
        int          shift_cnt;

        // Power-on reset
        #2 nTRST = 1'b0;
        #3;
        check("rst_state", 32'(TapState), 32'hF);
        check("rst_tdo", 32'(TDO), 32'h0);
        check("rst_tdoen", 32'(TDOEn), 32'h0);
        check("rst_strobes", 32'({CaptureDR, ShiftDR, UpdateDR}), 32'h0);
        #11 nTRST = 1'b1;

        // First edge after release evaluates TMS from TLR
        clk(1'b0, 1'b0);
        check("first_edge_rti", 32'(TapState), 32'hC);

        read_dr32(v);
        check("idcode_scan", v, 32'h1000_0001);

        // IR capture pattern while loading BYPASS
        load_ir(4'hF, cap);
        check("ir_capture", 32'(cap), 32'h1);

        // BYPASS: one-cycle delay, captured bit 0 first
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1); g[0] = last_tdo;
        clk(1'b0, 1'b0); g[1] = last_tdo;
        clk(1'b0, 1'b1); g[2] = last_tdo;
        clk(1'b0, 1'b1); g[3] = last_tdo;
        clk(1'b1, 1'b0); g[4] = last_tdo;
        check("bypass_seq", 32'(g), 32'h1A);
        check("bypass_tdoen_shift", 32'(last_tdoen), 32'h1);
        clk(1'b0, 1'b0);
        check("tdo_hold_ex1dr", 32'(last_tdo), 32'h1);
        check("tdoen_ex1dr", 32'(last_tdoen), 32'h0);
        check("pause_dr_state", 32'(TapState), 32'h3);
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        check("upd_dr_state", 32'(TapState), 32'h5);
        check("bypass_no_update", 32'(UpdateDR), 32'h0);
        clk(1'b0, 1'b0);

        // IR shift with PauseIR/Ex2IR round trip; ends with IR = 4'hE
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1); g[0] = last_tdo;
        clk(1'b1, 1'b0); g[1] = last_tdo;
        clk(1'b0, 1'b0);
        check("pause_ir_state", 32'(TapState), 32'hB);
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        check("ex2_ir_state", 32'(TapState), 32'h8);
        clk(1'b0, 1'b0);
        check("sh_ir_return", 32'(TapState), 32'hA);
        clk(1'b0, 1'b1); g[2] = last_tdo;
        clk(1'b0, 1'b1); g[3] = last_tdo;
        clk(1'b1, 1'b1); g[4] = last_tdo;
        check("ir_pause_seq", 32'(g), 32'h11);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        // Opcode 4'hE must behave as BYPASS (first bit out is captured 0)
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1); g[0] = last_tdo;
        clk(1'b1, 1'b0); g[1] = last_tdo;
        check("unknown_op_bypass", 32'(g[1:0]), 32'h2);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);

        // Watch chain
        load_ir(4'h2, cap);
        clk(1'b1, 1'b0);
        check("watch_seldr_cap", 32'(CaptureDR), 32'h0);
        clk(1'b0, 1'b0);
        check("watch_capdr", 32'({CaptureDR, ShiftDR, UpdateDR}), 32'h4);
        clk(1'b0, 1'b0);
        check("watch_shdr_cap", 32'(CaptureDR), 32'h0);
        shift_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ChainScanOut = (i != 1);
            if (ShiftDR === 1'b1) shift_cnt++;
            clk(i == 3, 1'b0);
            g[i] = last_tdo;
        end
        check("watch_tdo", 32'(g[3:0]), 32'hD);
        check("watch_shift_cycles", 32'(shift_cnt), 32'h4);
        check("watch_ex1dr_shift", 32'(ShiftDR), 32'h0);
        TDI = 1'b1;
        #1 check("chain_in_1", 32'(ChainScanIn), 32'h1);
        TDI = 1'b0;
        #1 check("chain_in_0", 32'(ChainScanIn), 32'h0);
        clk(1'b1, 1'b0);
        check("watch_upddr", 32'({CaptureDR, ShiftDR, UpdateDR}), 32'h1);
        clk(1'b0, 1'b0);
        check("watch_rti_upd", 32'(UpdateDR), 32'h0);

        // Five TMS=1 edges reach TLR from every state
        load_ir(4'hF, cap);
        walk(8'b0000_0000, 0, 4'hF);
        walk(8'b0000_0000, 1, 4'hC);
        walk(8'b0000_0010, 2, 4'h7);
        walk(8'b0000_0010, 3, 4'h6);
        walk(8'b0000_0010, 4, 4'h2);
        walk(8'b0000_1010, 4, 4'h1);
        walk(8'b0000_1010, 5, 4'h3);
        walk(8'b0010_1010, 6, 4'h0);
        walk(8'b0001_1010, 5, 4'h5);
        walk(8'b0000_0110, 3, 4'h4);
        walk(8'b0000_0110, 4, 4'hE);
        walk(8'b0000_0110, 5, 4'hA);
        walk(8'b0001_0110, 5, 4'h9);
        walk(8'b0001_0110, 6, 4'hB);
        walk(8'b0101_0110, 7, 4'h8);
        walk(8'b0011_0110, 6, 4'hD);
        read_dr32(v);
        check("tlr_ir_idcode", v, 32'h1000_0001);

        // Asynchronous reset in the middle of a BYPASS shift
        load_ir(4'hF, cap);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1);
        clk(1'b0, 1'b1);
        check("pre_rst_tdoen", 32'(TDOEn), 32'h1);
        check("pre_rst_tdo", 32'(TDO), 32'h1);
        #2 nTRST = 1'b0;
        #2;
        check("mid_rst_state", 32'(TapState), 32'hF);
        check("mid_rst_tdoen", 32'(TDOEn), 32'h0);
        check("mid_rst_tdo", 32'(TDO), 32'h0);
        #2 nTRST = 1'b1;
        read_dr32(v);
        check("post_rst_idcode", v, 32'h1000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IRWIDTH, default 4, instruction register width.
REQ-002 SHALL have parameter IDCODE, default 32'h1000_0001, device identification value (bit 0 = 1).
REQ-003 SHALL have parameter WATCHINSTR, default 4'h2, opcode that selects the watch chain.
REQ-004 SHALL have port TCK  input  1  test clock; the only clock.
REQ-005 SHALL have port nTRST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port TMS  input  1  mode select, sampled on rising TCK.
REQ-007 SHALL have port TDI  input  1  serial data in.
REQ-008 SHALL have port TDO  output  1  serial data out, registered.
REQ-009 SHALL have port TDOEn  output  1  TDO driver enable, registered.
REQ-010 SHALL have port ChainScanIn  output  1  serial data to watch chain; equals TDI combinationally.
REQ-011 SHALL have port ChainScanOut  input  1  serial data returned from watch chain.
REQ-012 SHALL have port CaptureDR  output  1  watch-chain capture strobe.
REQ-013 SHALL have port ShiftDR  output  1  watch-chain shift strobe.
REQ-014 SHALL have port UpdateDR  output  1  watch-chain update strobe.
REQ-015 SHALL have port TapState  output  4  current TAP state code, for debug.

Function
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM, state register clocked on rising TCK.
REQ-017 State codes SHALL be: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-018 Transitions, given as TMS=0 / TMS=1 successors: TLR: RTI/TLR; RTI: RTI/SelDR; SelDR: CapDR/SelIR; SelIR: CapIR/TLR; Cap: Sh/Ex1; Sh: Sh/Ex1; Ex1: Pause/Upd; Pause: Pause/Ex2; Ex2: Sh/Upd; Upd: RTI/SelDR. The Cap/Sh/Ex1/Pause/Ex2/Upd rows apply identically to the DR and IR columns.
REQ-019 Five consecutive rising TCK edges with TMS=1 SHALL reach TLR from any state.
REQ-020 IR shift register (IRWIDTH) SHALL load 'b0...01 on the edge leaving CapIR.
REQ-021 IR shift register SHALL shift right, TDI into MSB, on each edge while in ShIR.
REQ-022 IR SHALL load from the shift register on the edge leaving UpdIR.
REQ-023 While in TLR, IR SHALL hold opcode 4'h1 (IDCODE).
REQ-024 Decode: all-ones = BYPASS; 4'h1 = IDCODE; WATCHINSTR = WATCH; every other opcode SHALL act as BYPASS.
REQ-025 BYPASS register (1 bit) SHALL load 0 leaving CapDR and load TDI on each edge while in ShDR.
REQ-026 IDCODE register (32 bit) SHALL load IDCODE leaving CapDR and shift right, TDI into MSB, while in ShDR.
REQ-027 CaptureDR, ShiftDR and UpdateDR SHALL be combinational decodes of state CapDR, ShDR and UpdDR respectively, each ANDed with IR==WATCH; they SHALL be glitch-free because they decode registered state only.
REQ-028 TDO SHALL be registered on falling TCK with the selected serial LSB: IR LSB in ShIR; in ShDR, BYPASS bit, IDCODE LSB, or ChainScanOut per IR.
REQ-029 TDOEn SHALL be registered on falling TCK and SHALL be 1 only when the state is ShDR or ShIR.
REQ-030 Outside the shift states, TDO SHALL hold its last value.
REQ-031 TapState SHALL equal the state register.

Reset
REQ-032 nTRST low SHALL immediately force: state=TLR, IR=4'h1, IR shift register=0, BYPASS=0, IDCODE register=IDCODE, TDO=0, TDOEn=0.
REQ-033 Reset asserted mid-shift SHALL abort the shift; no IR or DR update occurs.
REQ-034 After nTRST release, the first rising TCK SHALL evaluate TMS from TLR.

Verification
REQ-035 Reset, then TMS 0,1,0,0 then 32 edges with TMS=0 in ShDR: TDO yields 32'h1000_0001, LSB first.
REQ-036 Load IR=4'hF via ShIR (TDI 1,1,1,1): DR path delays TDI by one TCK; pattern 1,0,1,1 appears on TDO one edge later; captured bit is 0.
REQ-037 Load IR=WATCHINSTR: CaptureDR is high exactly one cycle in CapDR; ShiftDR is high for N cycles in ShDR; TDO follows ChainScanOut; ChainScanIn equals TDI.
REQ-038 In ShIR, TDO shows the captured pattern 1,0,0,0; PauseIR/Ex2IR round-trip preserves the shift contents.
REQ-039 From each of the 16 states, 5 edges with TMS=1 -> TapState=F; IR=4'h1.
REQ-040 nTRST pulsed low during ShDR -> TapState=F, TDOEn=0, IR=4'h1 asynchronously, before the next TCK edge.
